dmem_port_scheduler: RTL and testbench
======================================

DMEM_PORT_SCHEDULER -- requirements
Module: dmem_port_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: memory/DMA data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: DMEM byte address width.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8: byte-enable width.
REQ-004 SHALL have parameter MAX_BURST, default 16: beats one DMA direction may hold the port while the other waits.
REQ-005 SHALL have ports clk in 1 (sole clock) and rst in 1 (synchronous, active-high reset), listed first.
REQ-006 SHALL have msg_wr_en in 1, msg_wr_addr in ADDR_WIDTH, msg_wr_strb in STRB_WIDTH, msg_wr_data in DATA_WIDTH: core-message write; always accepted, no ready.
REQ-007 SHALL have dma_wr_en in 1, dma_wr_addr in ADDR_WIDTH, dma_wr_strb in STRB_WIDTH, dma_wr_data in DATA_WIDTH, dma_wr_last in 1, dma_wr_ready out 1: DMA write beat.
REQ-008 SHALL have dma_rd_en in 1, dma_rd_addr in ADDR_WIDTH, dma_rd_last in 1, dma_rd_ready out 1: DMA read command beat.
REQ-009 SHALL have rd_resp_data out DATA_WIDTH, rd_resp_valid out 1, rd_resp_ready in 1: read response stream.
REQ-010 SHALL have mem_en out 1, mem_ren out 1, mem_wen out STRB_WIDTH, mem_addr out ADDR_WIDTH, mem_wr_data out DATA_WIDTH, mem_rd_data in DATA_WIDTH: single DMEM port, read data valid exactly 1 cycle after mem_ren.

Function
REQ-011 SHALL implement FSM states IDLE, WRITE, READ with one registered beat counter (width clog2(MAX_BURST)+1).
REQ-012 SHALL give msg_wr_en absolute priority: in that cycle mem_en=1, mem_ren=0, mem_wen=msg_wr_strb, mem_addr/mem_wr_data from msg; dma_wr_ready=dma_rd_ready=0; FSM state and beat counter unchanged.
REQ-013 Write beat accepted (dma_wr_en && dma_wr_ready) SHALL drive mem_en=1, mem_wen=dma_wr_strb, mem_addr=dma_wr_addr, mem_wr_data=dma_wr_data, same cycle (combinational).
REQ-014 Read beat accepted (dma_rd_en && dma_rd_ready) SHALL drive mem_en=1, mem_ren=1, mem_wen=0, mem_addr=dma_rd_addr.
REQ-015 Read grant SHALL require response space: (buffered+in_flight) < 2, or == 2 with rd_resp_valid && rd_resp_ready this cycle.
REQ-016 SHALL hold a 2-entry response FIFO capturing mem_rd_data the cycle after each accepted read; rd_resp_data from FIFO head; order preserved; no drop, no duplication.
REQ-017 IDLE: wr only -> WRITE; rd only (space available) -> READ; both -> WRITE; grant issued in the same cycle as the decision.
REQ-018 WRITE: only writes granted; exit to IDLE after beat with dma_wr_last, or when counter reaches MAX_BURST and dma_rd_en pending -> READ.
REQ-019 READ: only reads granted; exit to IDLE after beat with dma_rd_last, or when counter reaches MAX_BURST and dma_wr_en pending -> WRITE.
REQ-020 Counter SHALL reset to 0 on every state change, increment per accepted beat, saturate at MAX_BURST.
REQ-021 In READ with no response space: dma_rd_ready=0, state held, no mem access.
REQ-022 No accepted op: mem_en=0, mem_ren=0, mem_wen=0.
REQ-023 dma_wr_ready/dma_rd_ready SHALL NOT depend on the matching en input beyond gating by msg_wr_en, state and space.

Reset
REQ-024 On rst: state=IDLE, counter=0, FIFO empty, in_flight=0, rd_resp_valid=0, mem_en=mem_ren=0, mem_wen=0.
REQ-025 rst mid-burst SHALL abandon the burst; a read in flight during rst SHALL be discarded.
REQ-026 Outputs SHALL be defined the first cycle after rst deasserts; no X on valids/readys/enables.

Verification
REQ-027 4-beat write burst, addr 0x100..0x118, last on beat 4 -> mem_wen=0xFF for 4 consecutive cycles, then IDLE.
REQ-028 msg_wr_en asserted during beat 2 of a write burst -> that cycle carries msg addr/strb, dma_wr_ready=0; burst finishes one cycle later, counter unaffected.
REQ-029 rd_resp_ready=0, 5-beat read burst -> exactly 2 reads issued, dma_rd_ready=0 after; on release all 5 responses in order, no loss.
REQ-030 Continuous write (no last) plus pending read, MAX_BURST=16 -> switch to READ after write beat 16; read takes port the next cycle.
REQ-031 wr and rd asserted together from IDLE -> WRITE granted first.
REQ-032 rst asserted with 1 read in flight and 1 buffered -> rd_resp_valid=0 the cycle after; no stale response after reset.

Source files
------------

// File: rtl/dmem_port_scheduler.sv
// rtl/dmem_port_scheduler.sv - single DMEM port arbiter for core messages and DMA write/read bursts
//
// Purpose: shares one data-memory port between core message writes, which
// always win, and two DMA directions that take turns in bursts. Read
// responses are returned through a 2-entry FIFO so that read grants can be
// throttled by response back-pressure without losing data.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   msg_wr_*                        core message write (always accepted)
//   dma_wr_* / dma_wr_ready         DMA write beat
//   dma_rd_* / dma_rd_ready         DMA read command beat
//   rd_resp_data/valid/ready        read response stream
//   mem_*                           DMEM port, read data one cycle after mem_ren
module dmem_port_scheduler #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  msg_wr_en,
    input  logic [ADDR_WIDTH-1:0] msg_wr_addr,
    input  logic [STRB_WIDTH-1:0] msg_wr_strb,
    input  logic [DATA_WIDTH-1:0] msg_wr_data,
    input  logic                  dma_wr_en,
    input  logic [ADDR_WIDTH-1:0] dma_wr_addr,
    input  logic [STRB_WIDTH-1:0] dma_wr_strb,
    input  logic [DATA_WIDTH-1:0] dma_wr_data,
    input  logic                  dma_wr_last,
    output logic                  dma_wr_ready,
    input  logic                  dma_rd_en,
    input  logic [ADDR_WIDTH-1:0] dma_rd_addr,
    input  logic                  dma_rd_last,
    output logic                  dma_rd_ready,
    output logic [DATA_WIDTH-1:0] rd_resp_data,
    output logic                  rd_resp_valid,
    input  logic                  rd_resp_ready,
    output logic                  mem_en,
    output logic                  mem_ren,
    output logic [STRB_WIDTH-1:0] mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;

    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic            head_q;
    logic [1:0]      fill_q;
    logic            in_flight_q;

    logic [1:0]      occ;
    logic            push, pop, wr_idx;
    logic            rd_space, wr_fire, rd_fire;
    logic            cnt_at_max, inc_at_max;

    assign rd_resp_valid = (fill_q != 2'd0);
    assign rd_resp_data  = fifo_q[head_q];
    assign pop           = rd_resp_valid && rd_resp_ready;
    // Data of a read issued last cycle lands on mem_rd_data now.
    assign push          = in_flight_q;
    assign wr_idx        = head_q ^ fill_q[0];

    // Buffered plus outstanding responses; a pop this cycle frees one slot.
    assign occ      = fill_q + {1'b0, in_flight_q};
    assign rd_space = (occ < 2'd2) || ((occ == 2'd2) && pop);

    assign cnt_at_max = (cnt_q == MAX_CNT);
    assign cnt_inc    = cnt_at_max ? cnt_q : cnt_q + CW'(1);
    assign inc_at_max = (cnt_inc == MAX_CNT);

    always_comb begin
        dma_wr_ready = 1'b0;
        dma_rd_ready = 1'b0;
        if (!msg_wr_en) begin
            case (state_q)
                IDLE: begin
                    dma_wr_ready = 1'b1;
                    // Writes win a simultaneous request from IDLE.
                    dma_rd_ready = rd_space && !dma_wr_en;
                end
                // A saturated burst yields to a waiting opposite direction.
                WRITE:   dma_wr_ready = !(cnt_at_max && dma_rd_en);
                READ:    dma_rd_ready = rd_space && !(cnt_at_max && dma_wr_en);
                default: ;
            endcase
        end
    end

    assign wr_fire = dma_wr_en && dma_wr_ready;
    assign rd_fire = dma_rd_en && dma_rd_ready;

    always_comb begin
        mem_en      = 1'b0;
        mem_ren     = 1'b0;
        mem_wen     = '0;
        mem_addr    = '0;
        mem_wr_data = '0;
        if (msg_wr_en) begin
            mem_en      = 1'b1;
            mem_wen     = msg_wr_strb;
            mem_addr    = msg_wr_addr;
            mem_wr_data = msg_wr_data;
        end else if (wr_fire) begin
            mem_en      = 1'b1;
            mem_wen     = dma_wr_strb;
            mem_addr    = dma_wr_addr;
            mem_wr_data = dma_wr_data;
        end else if (rd_fire) begin
            mem_en   = 1'b1;
            mem_ren  = 1'b1;
            mem_addr = dma_rd_addr;
        end
    end

    // The beat granted from IDLE opens the burst and is counted as beat 1,
    // so a burst holds the port for MAX_BURST beats before yielding.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!msg_wr_en) begin
            case (state_q)
                IDLE: begin
                    if (wr_fire) begin
                        if (!dma_wr_last) begin
                            state_d = WRITE;
                            cnt_d   = CW'(1);
                        end
                    end else if (rd_fire) begin
                        if (!dma_rd_last) begin
                            state_d = READ;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                WRITE: begin
                    if (wr_fire) begin
                        if (dma_wr_last) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else if (inc_at_max && dma_rd_en) begin
                            state_d = READ;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (cnt_at_max && dma_rd_en) begin
                        state_d = READ;
                        cnt_d   = '0;
                    end
                end
                READ: begin
                    if (rd_fire) begin
                        if (dma_rd_last) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else if (inc_at_max && dma_wr_en) begin
                            state_d = WRITE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else if (cnt_at_max && dma_wr_en) begin
                        state_d = WRITE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            head_q      <= 1'b0;
            fill_q      <= 2'd0;
            in_flight_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_flight_q <= rd_fire;
            if (pop) begin
                head_q <= ~head_q;
            end
            fill_q <= fill_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage needs no reset; fill_q alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_q[wr_idx] <= mem_rd_data;
        end
    end

endmodule

// File: tb/tb_dmem_port_scheduler.sv
// tb/tb_dmem_port_scheduler.sv - directed self-checking bench for dmem_port_scheduler
module tb_dmem_port_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        msg_wr_en = 1'b0;
    logic [15:0] msg_wr_addr = '0;
    logic [7:0]  msg_wr_strb = '0;
    logic [63:0] msg_wr_data = '0;
    logic        dma_wr_en = 1'b0;
    logic [15:0] dma_wr_addr = '0;
    logic [7:0]  dma_wr_strb = '0;
    logic [63:0] dma_wr_data = '0;
    logic        dma_wr_last = 1'b0;
    logic        dma_wr_ready;
    logic        dma_rd_en = 1'b0;
    logic [15:0] dma_rd_addr = '0;
    logic        dma_rd_last = 1'b0;
    logic        dma_rd_ready;
    logic [63:0] rd_resp_data;
    logic        rd_resp_valid;
    logic        rd_resp_ready = 1'b0;
    logic        mem_en;
    logic        mem_ren;
    logic [7:0]  mem_wen;
    logic [15:0] mem_addr;
    logic [63:0] mem_wr_data;
    logic [63:0] mem_rd_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_port_scheduler #(
        .DATA_WIDTH(64), .ADDR_WIDTH(16), .STRB_WIDTH(8), .MAX_BURST(16)
    ) dut (
        .clk(clk), .rst(rst),
        .msg_wr_en(msg_wr_en), .msg_wr_addr(msg_wr_addr),
        .msg_wr_strb(msg_wr_strb), .msg_wr_data(msg_wr_data),
        .dma_wr_en(dma_wr_en), .dma_wr_addr(dma_wr_addr), .dma_wr_strb(dma_wr_strb),
        .dma_wr_data(dma_wr_data), .dma_wr_last(dma_wr_last), .dma_wr_ready(dma_wr_ready),
        .dma_rd_en(dma_rd_en), .dma_rd_addr(dma_rd_addr), .dma_rd_last(dma_rd_last),
        .dma_rd_ready(dma_rd_ready),
        .rd_resp_data(rd_resp_data), .rd_resp_valid(rd_resp_valid),
        .rd_resp_ready(rd_resp_ready),
        .mem_en(mem_en), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rdpat(input logic [15:0] a);
        return {16'hBEEF, a, ~a, 16'h1234};
    endfunction

    // Memory model: read data appears one cycle after mem_ren.
    logic        ren_s  = 1'b0;
    logic [15:0] addr_s = '0;
    always @(negedge clk) begin
        ren_s  <= mem_ren;
        addr_s <= mem_addr;
    end
    always @(posedge clk) begin
        if (ren_s) mem_rd_data <= rdpat(addr_s);
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) next();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rd_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rd_resp_valid); end
        n_tests++;
        if ({mem_en, mem_ren, mem_wen} !== 10'b0) begin n_fail++;
            $display("FAIL reset_mem: en=%b ren=%b wen=%h want all 0", mem_en, mem_ren, mem_wen); end
        n_tests++;
        if ({dma_wr_ready, dma_rd_ready} !== 2'b11) begin n_fail++;
            $display("FAIL reset_ready: wr=%b rd=%b want 1 1", dma_wr_ready, dma_rd_ready); end
        next();
    endtask

    task automatic test_write_burst();
        logic [15:0] a;
        for (int i = 0; i < 4; i++) begin
            a = 16'h0100 + 16'(i * 8);
            dma_wr_en = 1'b1; dma_wr_addr = a; dma_wr_strb = 8'hFF;
            dma_wr_data = 64'hD000_0000_0000_0000 | 64'(i); dma_wr_last = (i == 3);
            @(negedge clk);
            n_tests++;
            if (mem_en !== 1'b1 || mem_wen !== 8'hFF || mem_addr !== a || dma_wr_ready !== 1'b1 ||
                mem_wr_data !== (64'hD000_0000_0000_0000 | 64'(i))) begin
                n_fail++;
                $display("FAIL wr_burst_beat%0d: en=%b wen=%h addr=%h data=%h rdy=%b want 1 ff %h", i,
                         mem_en, mem_wen, mem_addr, mem_wr_data, dma_wr_ready, a);
            end
            next();
        end
        dma_wr_en = 1'b0; dma_wr_last = 1'b0;
        @(negedge clk);
        n_tests++;
        if (mem_en !== 1'b0 || dma_rd_ready !== 1'b1) begin n_fail++;
            $display("FAIL wr_burst_idle: mem_en=%b rd_ready=%b want 0 1", mem_en, dma_rd_ready); end
        next();
    endtask

    task automatic test_msg_priority();
        int beat = 0;
        logic [15:0] a;
        msg_wr_addr = 16'h3000; msg_wr_strb = 8'h0F; msg_wr_data = 64'h1111_2222_3333_4444;
        for (int cyc = 0; cyc < 5; cyc++) begin
            a = 16'h0200 + 16'(beat * 8);
            dma_wr_en = 1'b1; dma_wr_addr = a; dma_wr_strb = 8'hFF;
            dma_wr_data = 64'(beat); dma_wr_last = (beat == 3);
            msg_wr_en = (cyc == 1);
            @(negedge clk);
            n_tests++;
            if (cyc == 1) begin
                if (mem_addr !== 16'h3000 || mem_wen !== 8'h0F || mem_ren !== 1'b0 ||
                    mem_wr_data !== 64'h1111_2222_3333_4444 || dma_wr_ready !== 1'b0 ||
                    dma_rd_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL msg_prio: addr=%h wen=%h data=%h wr_rdy=%b rd_rdy=%b want 3000 0f msg 0 0",
                             mem_addr, mem_wen, mem_wr_data, dma_wr_ready, dma_rd_ready);
                end
            end else begin
                if (mem_addr !== a || mem_wen !== 8'hFF || dma_wr_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL msg_burst_cyc%0d: addr=%h wen=%h rdy=%b want %h ff 1",
                             cyc, mem_addr, mem_wen, dma_wr_ready, a);
                end
            end
            next();
            if (cyc != 1) beat++;
        end
        msg_wr_en = 1'b0; dma_wr_en = 1'b0; dma_wr_last = 1'b0;
        @(negedge clk);
        n_tests++;
        if (mem_en !== 1'b0 || dma_rd_ready !== 1'b1) begin n_fail++;
            $display("FAIL msg_burst_idle: mem_en=%b rd_ready=%b want 0 1", mem_en, dma_rd_ready); end
        next();
    endtask

    task automatic test_read_backpressure();
        int issued = 0;
        int got = 0;
        logic fire;
        rd_resp_ready = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            if (cyc == 6) rd_resp_ready = 1'b1;
            dma_rd_en   = (issued < 5);
            dma_rd_addr = 16'h0400 + 16'(issued * 8);
            dma_rd_last = (issued == 4);
            @(negedge clk);
            fire = 1'b0;
            if (cyc == 5) begin
                n_tests++;
                if (issued != 2 || dma_rd_ready !== 1'b0 || rd_resp_valid !== 1'b1) begin n_fail++;
                    $display("FAIL rd_stall: issued=%0d rd_ready=%b valid=%b want 2 0 1",
                             issued, dma_rd_ready, rd_resp_valid); end
            end
            if (dma_rd_en && dma_rd_ready) begin
                fire = 1'b1;
                n_tests++;
                if (mem_ren !== 1'b1 || mem_en !== 1'b1 || mem_wen !== 8'h00 || mem_addr !== dma_rd_addr) begin
                    n_fail++;
                    $display("FAIL rd_issue%0d: ren=%b wen=%h addr=%h want 1 00 %h",
                             issued, mem_ren, mem_wen, mem_addr, dma_rd_addr);
                end
            end
            if (rd_resp_valid && rd_resp_ready) begin
                n_tests++;
                if (rd_resp_data !== rdpat(16'h0400 + 16'(got * 8))) begin n_fail++;
                    $display("FAIL rd_resp%0d: got %h want %h", got, rd_resp_data,
                             rdpat(16'h0400 + 16'(got * 8))); end
                got++;
            end
            next();
            if (fire) issued++;
        end
        dma_rd_en = 1'b0; dma_rd_last = 1'b0;
        n_tests++;
        if (got != 5 || issued != 5) begin n_fail++;
            $display("FAIL rd_totals: responses=%0d issued=%0d want 5 5", got, issued); end
        @(negedge clk);
        n_tests++;
        if (rd_resp_valid !== 1'b0) begin n_fail++;
            $display("FAIL rd_no_dup: valid=%b want 0", rd_resp_valid); end
        next();
    endtask

    task automatic test_burst_switch();
        logic [15:0] a;
        rd_resp_ready = 1'b1;
        dma_rd_en = 1'b1; dma_rd_addr = 16'h0600; dma_rd_last = 1'b1;
        dma_wr_en = 1'b1; dma_wr_strb = 8'hFF; dma_wr_last = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a = 16'h0500 + 16'(i * 8);
            dma_wr_addr = a; dma_wr_data = 64'(i);
            @(negedge clk);
            n_tests++;
            if (dma_wr_ready !== 1'b1 || dma_rd_ready !== 1'b0 || mem_ren !== 1'b0 ||
                mem_wen !== 8'hFF || mem_addr !== a) begin
                n_fail++;
                $display("FAIL switch_wr%0d: wr_rdy=%b rd_rdy=%b ren=%b wen=%h addr=%h want 1 0 0 ff %h",
                         i, dma_wr_ready, dma_rd_ready, mem_ren, mem_wen, mem_addr, a);
            end
            next();
        end
        dma_wr_addr = 16'h0580;
        @(negedge clk);
        n_tests++;
        if (dma_wr_ready !== 1'b0 || dma_rd_ready !== 1'b1 || mem_ren !== 1'b1 || mem_addr !== 16'h0600) begin
            n_fail++;
            $display("FAIL switch_rd: wr_rdy=%b rd_rdy=%b ren=%b addr=%h want 0 1 1 0600",
                     dma_wr_ready, dma_rd_ready, mem_ren, mem_addr);
        end
        next();
        dma_wr_en = 1'b0; dma_rd_en = 1'b0; dma_rd_last = 1'b0;
        @(negedge clk);
        n_tests++;
        if (mem_en !== 1'b0 || rd_resp_valid !== 1'b0) begin n_fail++;
            $display("FAIL switch_after: mem_en=%b valid=%b want 0 0", mem_en, rd_resp_valid); end
        next();
        @(negedge clk);
        n_tests++;
        if (rd_resp_valid !== 1'b1 || rd_resp_data !== rdpat(16'h0600)) begin n_fail++;
            $display("FAIL switch_resp: valid=%b data=%h want 1 %h", rd_resp_valid, rd_resp_data,
                     rdpat(16'h0600)); end
        next();
    endtask

    task automatic test_reset_inflight();
        rd_resp_ready = 1'b0;
        dma_rd_en = 1'b1; dma_rd_last = 1'b0; dma_rd_addr = 16'h0700;
        @(negedge clk);
        n_tests++;
        if (dma_rd_ready !== 1'b1) begin n_fail++;
            $display("FAIL rst_rd0: rd_ready=%b want 1", dma_rd_ready); end
        next();
        dma_rd_addr = 16'h0708;
        @(negedge clk);
        n_tests++;
        if (dma_rd_ready !== 1'b1) begin n_fail++;
            $display("FAIL rst_rd1: rd_ready=%b want 1", dma_rd_ready); end
        next();
        dma_rd_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (rd_resp_valid !== 1'b1) begin n_fail++;
            $display("FAIL rst_pre: valid=%b want 1", rd_resp_valid); end
        next();
        rst = 1'b0;
        rd_resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (rd_resp_valid !== 1'b0 || mem_en !== 1'b0) begin n_fail++;
                $display("FAIL rst_post%0d: valid=%b mem_en=%b want 0 0", i, rd_resp_valid, mem_en); end
            next();
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_msg_priority();
        test_read_backpressure();
        test_burst_switch();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
